// File: rtl/alu_control_md.sv
// MIPS-32 ALU control decode plus an iterative multiply/divide engine
// that owns HI/LO and stalls the execute stage while it runs.
module alu_control_md #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] md_result,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              stall
);
    localparam int W  = DATA_W;
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [2*W:0]  acc;
    logic [W-1:0]  opnd;
    logic          is_div, dz, neg_q, neg_r;

    logic          rtype, is_md, is_mf, accept, last;
    logic          sgn, sa, sb;
    logic [W-1:0]  ma, mb;
    logic [W:0]    m_sum, d_sh, d_dif;
    logic [2*W-1:0] prod;
    logic [W-1:0]  q_fix, r_fix;

    assign rtype  = alu_op == 2'b10;
    assign is_md  = funct[5:2] == 4'b0110;
    assign is_mf  = funct == F_MFHI || funct == F_MFLO;
    assign accept = in_valid && rtype && is_md && state == S_IDLE;
    assign last   = cnt == CW'(W - 1);
    assign busy   = state != S_IDLE;
    assign stall  = in_valid && busy && rtype && (is_md || is_mf);

    assign md_result = !rtype          ? '0 :
                       funct == F_MFHI ? hi :
                       funct == F_MFLO ? lo : '0;

    always_comb begin
        alu_ctrl = 4'b1111;
        unique case (alu_op)
            2'b00: alu_ctrl = 4'b0010;
            2'b01: alu_ctrl = 4'b0110;
            2'b11: alu_ctrl = 4'b0000;
            default: begin
                case (funct)
                    6'b100000: alu_ctrl = 4'b0010;
                    6'b100010: alu_ctrl = 4'b0110;
                    6'b100100: alu_ctrl = 4'b0000;
                    6'b100101: alu_ctrl = 4'b0001;
                    6'b100110: alu_ctrl = 4'b0011;
                    6'b100111: alu_ctrl = 4'b1100;
                    6'b101010: alu_ctrl = 4'b0111;
                    6'b000000: alu_ctrl = 4'b1000;
                    6'b000010: alu_ctrl = 4'b1001;
                    F_MFHI, F_MFLO: alu_ctrl = 4'b1110;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: alu_ctrl = 4'b1101;
                    default: alu_ctrl = 4'b1111;
                endcase
            end
        endcase
    end

    // Even funct codes are the signed variants
    assign sgn = ~funct[0];
    assign sa  = sgn & op_a[W-1];
    assign sb  = sgn & op_b[W-1];
    assign ma  = sa ? -op_a : op_a;
    assign mb  = sb ? -op_b : op_b;

    // acc = {partial product, multiplier} or {remainder, quotient}
    assign m_sum = acc[2*W:W] + {1'b0, acc[0] ? opnd : {W{1'b0}}};
    assign d_sh  = {acc[2*W-1:W], acc[W-1]};
    assign d_dif = d_sh - {1'b0, opnd};

    assign prod  = neg_q ? -acc[2*W-1:0] : acc[2*W-1:0];
    assign q_fix = neg_q ? -acc[W-1:0] : acc[W-1:0];
    assign r_fix = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept)
                state_nx = !funct[1]     ? S_MUL :
                           op_b == '0    ? S_FIX : S_DIV;
            S_MUL, S_DIV: if (last) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    cnt    <= '0;
                    is_div <= funct[1];
                    dz     <= funct[1] && op_b == '0;
                    neg_q  <= sa ^ sb;
                    neg_r  <= sa;
                    opnd   <= funct[1] ? mb : ma;
                    acc    <= {{(W+1){1'b0}},
                               !funct[1] ? mb : op_b == '0 ? op_a : ma};
                end
                S_MUL: begin
                    acc <= {1'b0, m_sum, acc[W-1:1]};
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= d_dif[W] ? {d_sh, acc[W-2:0], 1'b0}
                                    : {d_dif, acc[W-2:0], 1'b1};
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (dz) begin
                        hi <= acc[W-1:0];
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        {hi, lo} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: decode sweep, directed and random mult/div
// against a 64-bit arithmetic model, stall, back-to-back and reset abort.
module tb_alu_control_md;
    localparam int W = 32;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] ADD   = 6'b100000;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic in_valid = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic [5:0] funct = 6'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [3:0] alu_ctrl;
    logic [W-1:0] md_result, hi, lo;
    logic busy, done, stall;

    int checks = 0;
    int errors = 0;

    alu_control_md #(.DATA_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .alu_ctrl(alu_ctrl), .md_result(md_result), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ctrl_ref(input logic [1:0] op,
                                            input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0000;
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100110: return 4'b0011;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b000000: return 4'b1000;
            6'b000010: return 4'b1001;
            MFHI, MFLO: return 4'b1110;
            MULT, MULTU, DIV, DIVU: return 4'b1101;
            default: return 4'b1111;
        endcase
    endfunction

    // Returns {hi, lo} using wide native arithmetic
    function automatic logic [63:0] md_model(input logic [5:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        if ((f == DIV || f == DIVU) && b == 0) begin
            r = {a, 32'hFFFF_FFFF};
        end else begin
            case (f)
                MULT:  r = 64'(sa * sb);
                MULTU: r = {32'b0, a} * {32'b0, b};
                DIV:   r = {32'(sa % sb), 32'(sa / sb)};
                DIVU:  r = {a % b, a / b};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b10; funct = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_op = 2'b00; funct = ADD;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_check(input string tag, input logic [5:0] f,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] e;
        int n, lat;
        e = md_model(f, a, b);
        lat = ((f == DIV || f == DIVU) && b == 0) ? 1 : W + 1;
        chk({tag, " idle"}, 64'(busy), 64'd0);
        issue(f, a, b);
        chk({tag, " busy"}, 64'(busy), 64'd1);
        wait_done(n);
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " hi"}, 64'(hi), 64'(e[63:32]));
        chk({tag, " lo"}, 64'(lo), 64'(e[31:0]));
        chk({tag, " busy@done"}, 64'(busy), 64'd0);
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b10; funct = MFHI; #1;
        chk({tag, " mfhi"}, 64'(md_result), 64'(e[63:32]));
        funct = MFLO; #1;
        chk({tag, " mflo"}, 64'(md_result), 64'(e[31:0]));
        in_valid = 1'b0; alu_op = 2'b00; funct = ADD;
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [6];
        c = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [5:0] fs [4];
        logic [63:0] e, e2;
        int n;
        fs = '{MULT, MULTU, DIV, DIVU};

        #1 reset_n = 1'b0;
        #20;
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst stall", 64'(stall), 64'd0);
        @(negedge clk) reset_n = 1'b1;

        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                alu_op = 2'(op); funct = 6'(f); #1;
                chk($sformatf("ctrl op%0d f%0h", op, f),
                    64'(alu_ctrl), 64'(ctrl_ref(2'(op), 6'(f))));
            end
        end
        alu_op = 2'b00; funct = ADD;

        run_check("mult", MULT, 32'hFFFF_FFFD, 32'd5);
        run_check("multu", MULTU, 32'hFFFF_FFFD, 32'd5);
        run_check("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2);
        run_check("divu 100/7", DIVU, 32'd100, 32'd7);
        run_check("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("divu /0", DIVU, 32'h0000_1234, 32'd0);
        run_check("div /0", DIV, 32'h8765_4321, 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            f = fs[$urandom_range(0, 3)];
            a = pick();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            run_check($sformatf("rnd%0d", i), f, a, b);
        end

        // MFHI and a second mult/div presented while busy must stall
        e = md_model(MULT, 32'h0000_1234, 32'hFFFF_0001);
        issue(MULT, 32'h0000_1234, 32'hFFFF_0001);
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'b10; funct = ADD; #1;
        chk("add busy stall", 64'(stall), 64'd0);
        chk("add busy ctrl", 64'(alu_ctrl), 64'd2);
        @(negedge clk);
        funct = MULTU; op_a = 32'd7; op_b = 32'd9; #1;
        chk("md busy stall", 64'(stall), 64'd1);
        @(negedge clk);
        funct = MFHI; #1;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            chk("mfhi held stall", 64'(stall), 64'd1);
            @(posedge clk); #1;
            n++;
        end
        chk("mfhi done seen", 64'(done), 64'd1);
        chk("mfhi stall@done", 64'(stall), 64'd0);
        chk("mfhi new hi", 64'(md_result), 64'(e[63:32]));
        chk("stall lo kept", 64'(lo), 64'(e[31:0]));
        @(posedge clk); #1;
        chk("mfhi no accept", 64'(busy), 64'd0);
        in_valid = 1'b0; alu_op = 2'b00; funct = ADD;

        // Back-to-back accept in the done cycle
        e  = md_model(MULT, 32'hDEAD_BEEF, 32'h0000_0101);
        e2 = md_model(MULTU, 32'hCAFE_F00D, 32'h1234_5678);
        issue(MULT, 32'hDEAD_BEEF, 32'h0000_0101);
        wait_done(n);
        chk("b2b first lat", 64'(n), 64'd33);
        chk("b2b first hi", 64'(hi), 64'(e[63:32]));
        in_valid = 1'b1; alu_op = 2'b10; funct = MULTU;
        op_a = 32'hCAFE_F00D; op_b = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_op = 2'b00; funct = ADD;
        chk("b2b busy", 64'(busy), 64'd1);
        wait_done(n);
        chk("b2b second lat", 64'(n), 64'd33);
        chk("b2b second hi", 64'(hi), 64'(e2[63:32]));
        chk("b2b second lo", 64'(lo), 64'(e2[31:0]));

        // Reset aborts a running multiply
        @(posedge clk); #1;
        issue(MULT, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort stays idle", 64'(done | busy), 64'd0);
        chk("abort lo after", 64'(lo), 64'd0);
        run_check("after abort", DIV, 32'hFFFF_FF9C, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
